fb_writer: RTL and testbench
============================

FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 40, framebuffer columns.
REQ-002 SHALL have parameter HEIGHT, default 30, framebuffer rows.
REQ-003 SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n; all state SHALL be clocked on the rising edge of clk.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have port cmd_op  input  2  operation: 00 SET, 01 CLEAR, 10 TOGGLE, 11 FILL.
REQ-009 SHALL have port cmd_x  input  6  pixel column.
REQ-010 SHALL have port cmd_y  input  5  pixel row.
REQ-011 SHALL have port cmd_value  input  1  fill value, FILL only.
REQ-012 SHALL have port framebuffer  output  WIDTH*HEIGHT  pixel store; bit index y*WIDTH+x; VGA reader input.
REQ-013 SHALL have port busy  output  1  high while in FILL state.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected pixel command.

Function
REQ-015 SHALL implement states IDLE and FILL.
REQ-016 cmd_ready SHALL be high in IDLE and low in FILL and while rst_n is low.
REQ-017 A command SHALL be accepted only on a clk edge with cmd_valid and cmd_ready both high; other cycles SHALL leave the framebuffer unchanged.
REQ-018 Accepted SET/CLEAR/TOGGLE SHALL set/clear/invert bit y*WIDTH+x, visible on framebuffer one cycle after acceptance (latency 1).
REQ-019 Pixel commands SHALL be accepted back-to-back, one per cycle, with no bubbles.
REQ-020 Pixel command with cmd_x>=WIDTH or cmd_y>=HEIGHT SHALL be accepted, SHALL write nothing, and SHALL pulse err high for exactly the following cycle.
REQ-021 Accepted FILL SHALL ignore cmd_x/cmd_y, latch cmd_value, clear row counter to 0, and enter FILL next cycle.
REQ-022 In FILL, each cycle SHALL write the latched value to all WIDTH bits of row counter, then increment the counter.
REQ-023 FILL SHALL last exactly HEIGHT cycles; after writing row HEIGHT-1 the block SHALL return to IDLE with cmd_ready high the next cycle.
REQ-024 busy SHALL be high exactly during the HEIGHT FILL-state cycles.
REQ-025 cmd_valid asserted during FILL SHALL be held off (not accepted, no effect); the pending command SHALL be accepted on the first IDLE cycle if still valid.
REQ-026 Row counter SHALL be wide enough for HEIGHT-1 and SHALL never wrap into row HEIGHT or beyond.
REQ-027 FILL SHALL never raise err.

Reset
REQ-028 On rst_n low, asynchronously: framebuffer all zeros, state IDLE, row counter 0, busy 0, err 0, cmd_ready 0.
REQ-029 Reset asserted mid-FILL SHALL abort the fill; framebuffer SHALL read all zeros; no partial rows survive.
REQ-030 First cycle after rst_n rises SHALL have cmd_ready high and accept a valid command.

Verification
REQ-031 SET (5,3) then TOGGLE (5,3) on consecutive cycles -> bit 125 reads 1 after first edge, 0 after second; err stays 0.
REQ-032 SET (40,0) and SET (0,30) -> framebuffer unchanged, err high one cycle after each; cmd_ready stays 1.
REQ-033 FILL value 1 at cycle 0 -> busy high cycles 1..30, rows 0..29 set progressively, all 1200 bits 1, cmd_ready high cycle 31.
REQ-034 SET (0,0) held valid during FILL value 0 -> not accepted until IDLE; final bit 0 = 1, all others 0.
REQ-035 rst_n pulsed low at FILL cycle 12 -> framebuffer all zeros, busy 0 immediately; after release, SET (39,29) sets bit 1199 only.

Source files
------------

// File: rtl/fb_writer.sv
// Single-bit-per-pixel framebuffer writer: pixel set/clear/toggle commands
// plus a row-by-row FILL sequence, with the whole store exposed to a reader.
module fb_writer #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [5:0]                cmd_x,
    input  logic [4:0]                cmd_y,
    input  logic                      cmd_value,
    output logic [WIDTH*HEIGHT-1:0]   framebuffer,
    output logic                      busy,
    output logic                      err
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_FILL   = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [ROW_W-1:0]   row_r;
    logic               fill_val_r;
    logic [NPIX-1:0]    fb_r;
    logic               err_r;
    logic               busy_r;
    logic               err_next_s;
    logic               busy_next_s;
    logic               accept_s;
    logic               in_range_s;
    logic               last_row_s;
    logic [IDX_W-1:0]   pix_idx_s;
    logic [IDX_W-1:0]   row_base_s;

    // Command decode: acceptance, bounds check and linear bit addresses.
    always_comb begin
        accept_s   = cmd_valid && (state_r == ST_IDLE);
        in_range_s = (32'(cmd_x) < 32'(WIDTH)) && (32'(cmd_y) < 32'(HEIGHT));
        last_row_s = (row_r == ROW_W'(HEIGHT - 1));
        pix_idx_s  = IDX_W'(32'(cmd_y) * 32'(WIDTH) + 32'(cmd_x));
        row_base_s = IDX_W'(32'(row_r) * 32'(WIDTH));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cmd_op == OP_FILL)) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (last_row_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered status flags.
    always_comb begin
        busy_next_s = (state_next_s == ST_FILL);
        if (accept_s && (cmd_op != OP_FILL) && !in_range_s) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = 1'b0;
        end
    end

    // Status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            err_r  <= err_next_s;
        end
    end

    // Pixel store, fill value latch and fill row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_r       <= '0;
            row_r      <= '0;
            fill_val_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (cmd_op == OP_FILL) begin
                            fill_val_r <= cmd_value;
                            row_r      <= '0;
                        end else if (in_range_s) begin
                            case (cmd_op)
                                OP_SET:    fb_r[pix_idx_s] <= 1'b1;
                                OP_CLEAR:  fb_r[pix_idx_s] <= 1'b0;
                                OP_TOGGLE: fb_r[pix_idx_s] <= ~fb_r[pix_idx_s];
                                default:   fb_r[pix_idx_s] <= fb_r[pix_idx_s];
                            endcase
                        end
                    end
                end
                ST_FILL: begin
                    fb_r[row_base_s +: WIDTH] <= {WIDTH{fill_val_r}};
                    // Counter parks at 0 after the last row so it never reaches HEIGHT.
                    if (last_row_s) begin
                        row_r <= '0;
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end
                default: row_r <= '0;
            endcase
        end
    end

    assign cmd_ready   = rst_n && (state_r == ST_IDLE);
    assign busy        = busy_r;
    assign err         = err_r;
    assign framebuffer = fb_r;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: pixel-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fb_writer;

    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [5:0]   cmd_x = 6'd0;
    logic [4:0]   cmd_y = 5'd0;
    logic         cmd_value = 1'b0;
    logic [N-1:0] framebuffer;
    logic         busy;
    logic         err;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: pixel array plus "rows still to fill" bookkeeping.
    logic [N-1:0] m_fb = '0;
    int           m_fill_left = 0;
    int           m_row = 0;
    bit           m_val = 1'b0;
    bit           m_err = 1'b0;

    fb_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_value   (cmd_value),
        .framebuffer (framebuffer),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model update on each clock edge, cleared asynchronously by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fb = '0;
            m_fill_left = 0;
            m_row = 0;
            m_val = 1'b0;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_fill_left > 0) begin
                for (int c = 0; c < W; c++) m_fb[m_row * W + c] = m_val;
                m_row++;
                m_fill_left--;
            end else if (cmd_valid) begin
                if (cmd_op == 2'b11) begin
                    m_val = cmd_value;
                    m_row = 0;
                    m_fill_left = H;
                end else if (int'(cmd_x) < W && int'(cmd_y) < H) begin
                    case (cmd_op)
                        2'b00:   m_fb[int'(cmd_y) * W + int'(cmd_x)] = 1'b1;
                        2'b01:   m_fb[int'(cmd_y) * W + int'(cmd_x)] = 1'b0;
                        default: m_fb[int'(cmd_y) * W + int'(cmd_x)] = ~m_fb[int'(cmd_y) * W + int'(cmd_x)];
                    endcase
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", N'(cmd_ready), N'(rst_n && (m_fill_left == 0)));
            chk("busy",  N'(busy),      N'(m_fill_left > 0));
            chk("err",   N'(err),       N'(m_err));
            chk("fb",    framebuffer,   m_fb);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input int x, input int y, input bit val);
        cmd_valid = v;
        cmd_op    = op;
        cmd_x     = 6'(x);
        cmd_y     = 5'(y);
        cmd_value = val;
    endtask

    logic [N-1:0] exp_v;

    initial begin
        rst_n = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_ready", N'(cmd_ready), N'(0));
        chk("rst_fb", framebuffer, '0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", N'(cmd_ready), N'(1));

        // SET then TOGGLE on the same pixel, back to back.
        drive(1'b1, 2'b00, 5, 3, 1'b0);
        step();
        chk("set_bit125", N'(framebuffer[125]), N'(1));
        drive(1'b1, 2'b10, 5, 3, 1'b0);
        step();
        chk("toggle_bit125", N'(framebuffer[125]), N'(0));
        chk("toggle_err", N'(err), N'(0));

        // Out-of-range pixels write nothing and pulse err.
        drive(1'b1, 2'b00, 40, 0, 1'b0);
        step();
        chk("oob_x_err", N'(err), N'(1));
        chk("oob_x_fb", framebuffer, '0);
        chk("oob_x_ready", N'(cmd_ready), N'(1));
        drive(1'b1, 2'b00, 0, 30, 1'b0);
        step();
        chk("oob_y_err", N'(err), N'(1));
        drive(1'b0, 2'b00, 0, 0, 1'b0);
        step();
        chk("err_one_cycle", N'(err), N'(0));
        chk("oob_fb", framebuffer, '0);

        // FILL with 1: busy for exactly H cycles, rows appear progressively.
        drive(1'b1, 2'b11, 7, 7, 1'b1);
        step();
        drive(1'b0, 2'b00, 0, 0, 1'b0);
        for (int i = 1; i <= H; i++) begin
            chk("fill_busy", N'(busy), N'(1));
            if (i == 16) begin
                exp_v = '0;
                for (int b = 0; b < 15 * W; b++) exp_v[b] = 1'b1;
                chk("fill_rows15", framebuffer, exp_v);
            end
            step();
        end
        chk("fill_done_busy", N'(busy), N'(0));
        chk("fill_done_ready", N'(cmd_ready), N'(1));
        chk("fill_all_ones", framebuffer, {N{1'b1}});

        // FILL 0 with a SET held pending until IDLE.
        drive(1'b1, 2'b11, 0, 0, 1'b0);
        step();
        drive(1'b1, 2'b00, 0, 0, 1'b0);
        for (int i = 1; i <= H; i++) step();
        chk("held_bit0_pre", N'(framebuffer[0]), N'(0));
        step();
        drive(1'b0, 2'b00, 0, 0, 1'b0);
        chk("held_set_fb", framebuffer, N'(1));

        // Reset in the middle of a fill.
        drive(1'b1, 2'b11, 0, 0, 1'b1);
        step();
        drive(1'b0, 2'b00, 0, 0, 1'b0);
        for (int i = 1; i < 12; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_fb", framebuffer, '0);
        chk("midrst_busy", N'(busy), N'(0));
        chk("midrst_ready", N'(cmd_ready), N'(0));
        step();
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 39, 29, 1'b0);
        step();
        drive(1'b0, 2'b00, 0, 0, 1'b0);
        exp_v = '0;
        exp_v[N-1] = 1'b1;
        chk("after_rst_set", framebuffer, exp_v);

        // Randomised traffic, including out-of-range coordinates and rare fills.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(3, 0) != 0),
                  ($urandom_range(15, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0)),
                  int'($urandom_range(47, 0)), int'($urandom_range(31, 0)),
                  1'($urandom_range(1, 0)));
            step();
        end
        drive(1'b0, 2'b00, 0, 0, 1'b0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
